// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, branch funct3 codes, writeback
// selects, the E->M pipeline bundle and the branch-condition decoder.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [REGW-1:0] rd;
        logic [1:0]      result_src;
        logic            reg_write;
        logic            mem_write;
    } mem_bundle_t;

    localparam int unsigned MEM_BUNDLE_W = $bits(mem_bundle_t);

    // Flags come from A + ~B + 1, so carry set means A >= B unsigned.
    function automatic logic branch_cond(
        input logic [2:0] funct3,
        input logic       zero,
        input logic       negative,
        input logic       carry,
        input logic       overflow
    );
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = negative ^ overflow;
            F3_BGE:  taken = ~(negative ^ overflow);
            F3_BLTU: taken = ~carry;
            F3_BGEU: taken = carry;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer: an output register plus one skid slot.
// Upstream ready comes straight from the skid-valid flop.
module pipe_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_accept;
    logic w_xfer;
    logic w_skid_to_out;
    logic w_load_out;
    logic w_load_skid;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;

    assign w_accept      = i_valid & ~r_skid_valid;
    assign w_xfer        = r_out_valid & i_ready;
    assign w_skid_to_out = w_xfer & r_skid_valid;
    // An accept can only happen with SKID empty, so OUT takes it whenever it drains.
    assign w_load_out    = w_accept & (~r_out_valid | w_xfer);
    assign w_load_skid   = w_accept & r_out_valid & ~w_xfer;

    // Next occupancy of the two slots
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (w_skid_to_out) begin
            w_out_valid_nxt  = 1'b1;
            w_skid_valid_nxt = 1'b0;
        end else if (w_load_out) begin
            w_out_valid_nxt  = 1'b1;
        end else if (w_xfer) begin
            w_out_valid_nxt  = 1'b0;
        end
        if (w_load_skid) begin
            w_skid_valid_nxt = 1'b1;
        end
        if (i_flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end
    end

    // Valid bits and payload registers; payload moves only on load
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
            end else if (w_load_out) begin
                r_out_data <= i_data;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: resolves branch/jump redirects from ALU flags and
// registers the E bundle into M through a two-entry skid buffer.
module ex_mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidE,
    output logic            ReadyE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            ZeroE,
    input  logic            NegativeE,
    input  logic            CarryE,
    input  logic            OverFlowE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [REGW-1:0] RdE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    output logic            PCSrcE,
    input  logic            FlushM,
    output logic            ValidM,
    input  logic            ReadyM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [REGW-1:0] RdM,
    output logic [1:0]      ResultSrcM,
    output logic            RegWriteM,
    output logic            MemWriteM
);

    mem_bundle_t w_bundle_e;
    mem_bundle_t w_bundle_m;
    logic        w_ready_e;
    logic        w_valid_m;
    logic        w_taken;

    assign w_bundle_e = '{
        alu_result: ALUResultE,
        write_data: WriteDataE,
        pc_plus4:   PCPlus4E,
        rd:         RdE,
        result_src: ResultSrcE,
        reg_write:  RegWriteE,
        mem_write:  MemWriteE
    };

    pipe_skid_buffer #(
        .WIDTH (MEM_BUNDLE_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (FlushM),
        .i_valid (ValidE),
        .o_ready (w_ready_e),
        .i_data  (w_bundle_e),
        .o_valid (w_valid_m),
        .i_ready (ReadyM),
        .o_data  (w_bundle_m)
    );

    // Redirect only for a bundle actually accepted this cycle; the target
    // itself is forwarded to fetch directly from PCTargetE.
    assign w_taken = branch_cond(Funct3E, ZeroE, NegativeE, CarryE, OverFlowE);
    assign PCSrcE  = ValidE & w_ready_e & (JumpE | (BranchE & w_taken));

    assign ReadyE     = w_ready_e;
    assign ValidM     = w_valid_m;
    assign ALUResultM = w_bundle_m.alu_result;
    assign WriteDataM = w_bundle_m.write_data;
    assign PCPlus4M   = w_bundle_m.pc_plus4;
    assign RdM        = w_bundle_m.rd;
    assign ResultSrcM = w_bundle_m.result_src;
    assign RegWriteM  = w_bundle_m.reg_write & w_valid_m;
    assign MemWriteM  = w_bundle_m.mem_write & w_valid_m;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// valid/ready/flush stress run against a FIFO reference model.
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        ValidE, ReadyE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
    logic        ZeroE, NegativeE, CarryE, OverFlowE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic        PCSrcE, FlushM, ValidM, ReadyM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM, MemWriteM;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic        rw;
        logic        mw;
    } beat_t;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .ReadyE(ReadyE),
        .ALUResultE(ALUResultE), .ZeroE(ZeroE), .NegativeE(NegativeE),
        .CarryE(CarryE), .OverFlowE(OverFlowE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
        .PCSrcE(PCSrcE), .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ValidE = 0; ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; PCTargetE = 0;
        ZeroE = 0; NegativeE = 0; CarryE = 0; OverFlowE = 0; RdE = 0;
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
        ResultSrcE = 0; Funct3E = 0; FlushM = 0;
    endtask

    task automatic set_beat(input logic [31:0] alu, input logic [4:0] rd,
                            input logic rw, input logic mw);
        ValidE = 1; ALUResultE = alu; RdE = rd; RegWriteE = rw; MemWriteE = mw;
        WriteDataE = ~alu; PCPlus4E = alu + 32'd4;
    endtask

    task automatic test_reset();
        clear_inputs();
        ReadyM = 0;
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        n_cmp++; if (ValidM !== 1'b0) begin n_err++; $display("FAIL reset_validm: got %b want 0", ValidM); end
        n_cmp++; if (ALUResultM !== 32'h0) begin n_err++; $display("FAIL reset_alu: got %h want 0", ALUResultM); end
        n_cmp++; if (RdM !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", RdM); end
        n_cmp++; if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b%b want 00", RegWriteM, MemWriteM); end
        n_cmp++; if (ReadyE !== 1'b1) begin n_err++; $display("FAIL reset_readye: got %b want 1", ReadyE); end
    endtask

    task automatic test_single_beat();
        ReadyM = 1;
        set_beat(32'h0000_0010, 5'd5, 1'b1, 1'b0);
        #1;
        n_cmp++; if (ReadyE !== 1'b1) begin n_err++; $display("FAIL single_readye: got %b want 1", ReadyE); end
        @(negedge clk);
        ValidE = 0;
        #1;
        n_cmp++; if (ValidM !== 1'b1) begin n_err++; $display("FAIL single_validm: got %b want 1", ValidM); end
        n_cmp++; if (ALUResultM !== 32'h10) begin n_err++; $display("FAIL single_alu: got %h want 10", ALUResultM); end
        n_cmp++; if (RdM !== 5'd5) begin n_err++; $display("FAIL single_rd: got %0d want 5", RdM); end
        n_cmp++; if (RegWriteM !== 1'b1) begin n_err++; $display("FAIL single_regwrite: got %b want 1", RegWriteM); end
        @(negedge clk);
        #1;
        n_cmp++; if (ValidM !== 1'b0 || RegWriteM !== 1'b0) begin n_err++; $display("FAIL single_drain: got valid=%b rw=%b want 0 0", ValidM, RegWriteM); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        ReadyM = 0;
        set_beat(32'h1, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        set_beat(32'h2, 5'd2, 1'b1, 1'b0);
        #1;
        n_cmp++; if (ValidM !== 1'b1 || ALUResultM !== 32'h1) begin n_err++; $display("FAIL bp_a_in_out: got v=%b %h want 1 00000001", ValidM, ALUResultM); end
        @(negedge clk);
        set_beat(32'h3, 5'd3, 1'b1, 1'b0);
        JumpE = 1;
        #1;
        n_cmp++; if (ReadyE !== 1'b0) begin n_err++; $display("FAIL bp_readye_low: got %b want 0", ReadyE); end
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL jump_not_accepted: got %b want 0", PCSrcE); end
        n_cmp++; if (ALUResultM !== 32'h1) begin n_err++; $display("FAIL bp_hold_a: got %h want 00000001", ALUResultM); end
        @(negedge clk);
        #1;
        n_cmp++; if (ReadyE !== 1'b0 || ALUResultM !== 32'h1) begin n_err++; $display("FAIL bp_stall_stable: got rdy=%b %h want 0 00000001", ReadyE, ALUResultM); end
        ReadyM = 1;
        #1;
        n_cmp++; if (ReadyE !== 1'b0) begin n_err++; $display("FAIL bp_no_comb_ready: got %b want 0", ReadyE); end
        @(negedge clk);
        #1;
        n_cmp++; if (ValidM !== 1'b1 || ALUResultM !== 32'h2) begin n_err++; $display("FAIL bp_b: got v=%b %h want 1 00000002", ValidM, ALUResultM); end
        n_cmp++; if (ReadyE !== 1'b1) begin n_err++; $display("FAIL bp_recover: got %b want 1", ReadyE); end
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL jump_accepted: got %b want 1", PCSrcE); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (ValidM !== 1'b1 || ALUResultM !== 32'h3) begin n_err++; $display("FAIL bp_c: got v=%b %h want 1 00000003", ValidM, ALUResultM); end
        @(negedge clk);
        #1;
        n_cmp++; if (ValidM !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", ValidM); end
    endtask

    task automatic test_branch();
        clear_inputs();
        ReadyM = 1;
        ValidE = 1; BranchE = 1;
        ZeroE = 1; Funct3E = 3'b000; #1;
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL br_beq: got %b want 1", PCSrcE); end
        Funct3E = 3'b001; #1;
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL br_bne: got %b want 0", PCSrcE); end
        ZeroE = 0; NegativeE = 1; OverFlowE = 1; Funct3E = 3'b100; #1;
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL br_blt: got %b want 0", PCSrcE); end
        Funct3E = 3'b101; #1;
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL br_bge: got %b want 1", PCSrcE); end
        NegativeE = 0; OverFlowE = 0; CarryE = 0; Funct3E = 3'b110; #1;
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL br_bltu: got %b want 1", PCSrcE); end
        Funct3E = 3'b111; #1;
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL br_bgeu: got %b want 0", PCSrcE); end
        ZeroE = 1; Funct3E = 3'b010; #1;
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL br_f3_010: got %b want 0", PCSrcE); end
        ValidE = 0; JumpE = 1; #1;
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL br_not_valid: got %b want 0", PCSrcE); end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        clear_inputs();
        ReadyM = 0;
        set_beat(32'hA, 5'd10, 1'b1, 1'b1);
        @(negedge clk);
        set_beat(32'hB, 5'd11, 1'b1, 1'b1);
        @(negedge clk);
        set_beat(32'hC, 5'd12, 1'b1, 1'b1);
        FlushM = 1;
        #1;
        n_cmp++; if (ReadyE !== 1'b0 || ValidM !== 1'b1 || MemWriteM !== 1'b1) begin n_err++; $display("FAIL flush_pre_full: got rdy=%b v=%b mw=%b want 0 1 1", ReadyE, ValidM, MemWriteM); end
        n_cmp++; if (PCSrcE !== 1'b0) begin n_err++; $display("FAIL flush_pcsrc: got %b want 0", PCSrcE); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (ValidM !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin n_err++; $display("FAIL flush_cleared: got v=%b rw=%b mw=%b want 0 0 0", ValidM, RegWriteM, MemWriteM); end
        n_cmp++; if (ReadyE !== 1'b1) begin n_err++; $display("FAIL flush_readye: got %b want 1", ReadyE); end
        ReadyM = 1;
        @(negedge clk);
        #1;
        n_cmp++; if (ValidM !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost: got %b want 0", ValidM); end
        // Flush while an accepted beat would go to OUT: that beat is dropped.
        ReadyM = 0;
        set_beat(32'hD, 5'd13, 1'b1, 1'b0);
        FlushM = 1;
        JumpE = 1;
        #1;
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL flush_keeps_pcsrc: got %b want 1", PCSrcE); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (ValidM !== 1'b0 || ReadyE !== 1'b1) begin n_err++; $display("FAIL flush_drop_incoming: got v=%b rdy=%b want 0 1", ValidM, ReadyE); end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        ReadyM = 0;
        set_beat(32'h1111, 5'd1, 1'b1, 1'b1);
        @(negedge clk);
        set_beat(32'h2222, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (ReadyE !== 1'b0 || ALUResultM !== 32'h1111) begin n_err++; $display("FAIL rst_stall_pre: got rdy=%b %h want 0 00001111", ReadyE, ALUResultM); end
        rst = 0;
        @(negedge clk);
        rst = 1;
        #1;
        n_cmp++; if (ValidM !== 1'b0 || ALUResultM !== 32'h0) begin n_err++; $display("FAIL rst_stall_out: got v=%b %h want 0 00000000", ValidM, ALUResultM); end
        n_cmp++; if (ReadyE !== 1'b1 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin n_err++; $display("FAIL rst_stall_ctrl: got rdy=%b rw=%b mw=%b want 1 0 0", ReadyE, RegWriteM, MemWriteM); end
        ReadyM = 1;
        @(negedge clk);
        #1;
        n_cmp++; if (ValidM !== 1'b0) begin n_err++; $display("FAIL rst_stall_no_skid: got %b want 0", ValidM); end
    endtask

    task automatic test_random_stress();
        beat_t q[$];
        beat_t b;
        int    n_xfer = 0;
        int    n_fail_print = 0;
        logic [31:0] opa, opb;
        logic [32:0] sum;
        logic        taken, exp_pcsrc, rdy_before;
        clear_inputs();
        ReadyM = 0;
        rst = 0;
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 10000; i++) begin
            ValidE     = ($urandom_range(0, 9) < 7);
            ReadyM     = ($urandom_range(0, 9) < 6);
            FlushM     = ($urandom_range(0, 63) == 0);
            ALUResultE = $urandom; WriteDataE = $urandom; PCPlus4E = $urandom;
            PCTargetE  = $urandom;
            RdE = 5'($urandom); ResultSrcE = 2'($urandom_range(0, 2));
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
            BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
            Funct3E = 3'($urandom);
            opa = $urandom;
            opb = ($urandom_range(0, 3) == 0) ? opa : $urandom;
            sum = {1'b0, opa} + {1'b0, ~opb} + 33'd1;
            ZeroE = (opa == opb); NegativeE = sum[31]; CarryE = sum[32];
            OverFlowE = (opa[31] != opb[31]) && (sum[31] != opa[31]);
            case (Funct3E)
                3'b000:  taken = (opa == opb);
                3'b001:  taken = (opa != opb);
                3'b100:  taken = ($signed(opa) <  $signed(opb));
                3'b101:  taken = ($signed(opa) >= $signed(opb));
                3'b110:  taken = (opa <  opb);
                3'b111:  taken = (opa >= opb);
                default: taken = 1'b0;
            endcase
            exp_pcsrc = ValidE && (q.size() < 2) && (JumpE || (BranchE && taken));
            #1;
            n_cmp++;
            if (ReadyE !== (q.size() < 2) || ValidM !== (q.size() > 0) || PCSrcE !== exp_pcsrc) begin
                n_err++;
                if (n_fail_print++ < 20) $display("FAIL rnd_ctrl cyc %0d: got rdy=%b v=%b pc=%b want %b %b %b", i, ReadyE, ValidM, PCSrcE, q.size() < 2, q.size() > 0, exp_pcsrc);
            end
            if (q.size() > 0) begin
                b = q[0];
                n_cmp++;
                if (ALUResultM !== b.alu || WriteDataM !== b.wd || PCPlus4M !== b.pc4 || RdM !== b.rd ||
                    ResultSrcM !== b.rs || RegWriteM !== b.rw || MemWriteM !== b.mw) begin
                    n_err++;
                    if (n_fail_print++ < 20) $display("FAIL rnd_data cyc %0d: got %h %h %h %0d %0d %b%b want %h %h %h %0d %0d %b%b", i, ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM, RegWriteM, MemWriteM, b.alu, b.wd, b.pc4, b.rd, b.rs, b.rw, b.mw);
                end
            end
            rdy_before = ReadyE;
            ReadyM = ~ReadyM;
            #1;
            n_cmp++;
            if (ReadyE !== rdy_before) begin
                n_err++;
                if (n_fail_print++ < 20) $display("FAIL rnd_comb_ready cyc %0d: got %b want %b", i, ReadyE, rdy_before);
            end
            ReadyM = ~ReadyM;
            #1;
            if (q.size() > 0 && ReadyM) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (ValidE && rdy_before) begin
                b.alu = ALUResultE; b.wd = WriteDataE; b.pc4 = PCPlus4E; b.rd = RdE;
                b.rs = ResultSrcE; b.rw = RegWriteE; b.mw = MemWriteE;
                q.push_back(b);
            end
            if (FlushM) q.delete();
            @(negedge clk);
        end
        n_cmp++;
        if (n_xfer < 1000) begin n_err++; $display("FAIL rnd_throughput: got %0d transfers want >= 1000", n_xfer); end
        clear_inputs();
    endtask

    initial begin
        rst = 0;
        ReadyM = 0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_branch();
        test_flush();
        test_reset_mid_stall();
        test_random_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the 32-bit RISC-V core. It consumes the ALU's result and flags together with the E-stage control bundle, and resolves branch/jump redirects from those flags. It registers everything into the M stage through a two-entry skid buffer with valid/ready handshakes on both sides, so a memory-side stall never creates a combinational ready path back into execute.

## Interface
- XLEN, 32, datapath width
- REGW, 5, register-index width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (one clock, sampled on clk)
- ValidE  in  1  E-stage bundle valid
- ReadyE  out  1  stage can accept the E bundle this cycle
- ALUResultE  in  XLEN  ALU result
- ZeroE, NegativeE, CarryE, OverFlowE  in  1 each  ALU flags; for branches these come from the subtract A + ~B + 1
- WriteDataE  in  XLEN  store data
- RdE  in  REGW  destination register
- PCPlus4E, PCTargetE  in  XLEN  link address, branch/jump target
- RegWriteE, MemWriteE, BranchE, JumpE  in  1 each  control
- ResultSrcE  in  2  writeback select
- Funct3E  in  3  branch condition
- PCSrcE  out  1  redirect fetch to PCTargetE (combinational)
- FlushM  in  1  kill all held and incoming entries
- ValidM  out  1  M-stage bundle valid
- ReadyM  in  1  memory stage accepts the M bundle
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered copies
- RdM  out  REGW
- ResultSrcM  out  2
- RegWriteM, MemWriteM  out  1 each  gated by ValidM

## Operation
- An accept happens in a cycle when ValidE & ReadyE. A transfer out happens when ValidM & ReadyM.
- Storage is an output register (OUT) plus a skid register (SKID), each holding the full bundle and a valid bit.
- On accept:
  - If OUT is empty, or OUT transfers this cycle while SKID is empty, the bundle loads OUT.
  - Otherwise it loads SKID.
- On a transfer with SKID valid: SKID moves into OUT and SKID empties. A simultaneous accept cannot occur, because ReadyE=0 whenever SKID is valid.
- ReadyE = ~SKID.valid. It is driven directly from a flop and has no path from ReadyM.
- ValidM = OUT.valid. RegWriteM = OUT.RegWrite & ValidM. MemWriteM = OUT.MemWrite & ValidM.
- Branch condition, decoded from Funct3E:
  - 000 BEQ: ZeroE
  - 001 BNE: ~ZeroE
  - 100 BLT: NegativeE ^ OverFlowE
  - 101 BGE: ~(NegativeE ^ OverFlowE)
  - 110 BLTU: ~CarryE
  - 111 BGEU: CarryE
  - 010, 011: never taken
- PCSrcE = ValidE & ReadyE & (JumpE | (BranchE & cond)). No redirect is issued for a bundle that is not accepted that cycle.
- FlushM: at the next edge OUT.valid=0 and SKID.valid=0. A bundle accepted in the same cycle is dropped. PCSrcE is not affected.
- Data fields are loaded only on accept and are never cleared except by reset.

## Timing
- Reset (rst=0 at an edge): OUT.valid=0, SKID.valid=0, all M data/control outputs 0, ReadyE=1 from the next cycle. Reset mid-stall discards both entries.
- Latency: a bundle accepted at edge N with an empty or draining OUT presents ValidM=1 after edge N.
- Throughput: one bundle per cycle while ReadyM=1.
- Stall: with OUT full and ReadyM=0, one more bundle is absorbed into SKID. ReadyE falls after that edge.
- Recovery: ReadyE returns to 1 one cycle after ReadyM reasserts.
- Ordering: bundles leave in strict arrival order. No drop or duplication except by FlushM or reset.
- ValidM, once high, holds with stable data until a transfer, FlushM, or reset.
- Simultaneous FlushM and transfer out: the transfer counts downstream, and both entries are still cleared.

## Structure
- Shared package riscv_pkg holds:
  - branch Funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - ResultSrc encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10
  - XLEN/REGW defaults
- One sub-module, pipe_skid_buffer: parameterised on WIDTH, holding OUT/SKID and the handshake logic. The M-stage bundle is packed into it.
- Branch resolution and output gating live in ex_mem_stage.

## Test plan
- Reset then single beat: ALUResultE=0x0000_0010, RdE=5, RegWriteE=1, ReadyM=1 -> next cycle ValidM=1, ALUResultM=0x10, RdM=5, RegWriteM=1. The cycle after, with ValidE=0, gives ValidM=0.
- Back-pressure: hold ReadyM=0 and drive beats A=0x1, B=0x2, C=0x3 -> A in OUT, B in SKID, ReadyE=0 so C is held upstream. Release ReadyM -> M sees A, B, C on consecutive cycles, in order.
- Branches: ZeroE=1, BranchE=1, Funct3E=000 -> PCSrcE=1. Funct3E=001 -> 0. BLT with NegativeE=1, OverFlowE=1 -> 0. BLTU with CarryE=0 -> 1. JumpE=1 with ReadyE=0 -> PCSrcE=0.
- Flush: OUT and SKID full, FlushM=1 with ValidE=1 -> next cycle ValidM=0, RegWriteM=0, MemWriteM=0, ReadyE=1. The incoming beat never appears.
- Reset mid-stall: both entries full, rst=0 for one edge -> ValidM=0, ALUResultM=0, ReadyE=1 afterwards.
- Random valid/ready stress over 10k cycles against a FIFO scoreboard -> zero mismatches, ReadyE never depends combinationally on ReadyM.
